// File: rtl/alu_multi.sv
// rtl/alu_multi.sv - parametrised multi-accumulator ALU with flags and a shift-add multiplier
module alu_multi #(
    parameter int WIDTH = 8,
    parameter int NUM_ACC = 2,
    localparam int SEL_W = $clog2(NUM_ACC)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [3:0]       opcode,
    input  logic [SEL_W-1:0] sel,
    input  logic [WIDTH-1:0] data_in,
    output logic [WIDTH-1:0] data_out,
    output logic             busy
);

    typedef enum logic [3:0] {
        OP_NOP  = 4'h0, OP_LD   = 4'h1, OP_ADD  = 4'h2, OP_ADC  = 4'h3,
        OP_SUB  = 4'h4, OP_SBB  = 4'h5, OP_AND  = 4'h6, OP_OR   = 4'h7,
        OP_XOR  = 4'h8, OP_SHL  = 4'h9, OP_SHR  = 4'hA, OP_MUL  = 4'hB,
        OP_CMP  = 4'hC, OP_MOV  = 4'hD, OP_CLRF = 4'hE, OP_RDST = 4'hF
    } op_e;

    op_e                  op;
    logic [WIDTH-1:0]     acc [NUM_ACC];
    logic [3:0]           status;
    logic [3:0]           status_nxt;
    logic                 show_status;
    logic [SEL_W-1:0]     out_sel;
    logic [SEL_W-1:0]     mul_sel;
    logic [2*WIDTH-1:0]   mcand;
    logic [2*WIDTH-1:0]   product;
    logic [2*WIDTH-1:0]   product_nxt;
    logic [WIDTH-1:0]     mplier;
    logic [WIDTH-1:0]     mul_lo;
    logic [WIDTH-1:0]     mul_hi;
    logic [4:0]           mul_cnt;
    logic [WIDTH-1:0]     a;
    logic [WIDTH-1:0]     res;
    logic [WIDTH:0]       wide;
    logic                 wr_acc;
    logic                 upd_zn;

    assign op = op_e'(opcode);

    // Status bit order is {V, C, N, Z}; res is also the Z/N source for CMP, which does not write back.
    always_comb begin
        a          = acc[sel];
        res        = a;
        wide       = '0;
        wr_acc     = 1'b0;
        upd_zn     = 1'b0;
        status_nxt = status;
        case (op)
            OP_LD: begin
                res    = data_in;
                wr_acc = 1'b1;
                upd_zn = 1'b1;
            end
            OP_ADD, OP_ADC: begin
                wide = {1'b0, a} + {1'b0, data_in} + (WIDTH+1)'((op == OP_ADC) && status[2]);
                res  = wide[WIDTH-1:0];
                wr_acc = 1'b1;
                upd_zn = 1'b1;
                status_nxt[2] = wide[WIDTH];
                status_nxt[3] = (a[WIDTH-1] == data_in[WIDTH-1]) && (res[WIDTH-1] != a[WIDTH-1]);
            end
            OP_SUB, OP_SBB, OP_CMP: begin
                wide = {1'b0, a} - {1'b0, data_in} - (WIDTH+1)'((op == OP_SBB) && status[2]);
                res  = wide[WIDTH-1:0];
                wr_acc = (op != OP_CMP);
                upd_zn = 1'b1;
                status_nxt[2] = wide[WIDTH];
                status_nxt[3] = (a[WIDTH-1] != data_in[WIDTH-1]) && (res[WIDTH-1] != a[WIDTH-1]);
            end
            OP_AND, OP_OR, OP_XOR: begin
                if (op == OP_AND)     res = a & data_in;
                else if (op == OP_OR) res = a | data_in;
                else                  res = a ^ data_in;
                wr_acc = 1'b1;
                upd_zn = 1'b1;
                status_nxt[3] = 1'b0;
            end
            OP_SHL: begin
                res    = {a[WIDTH-2:0], 1'b0};
                wr_acc = 1'b1;
                upd_zn = 1'b1;
                status_nxt[2] = a[WIDTH-1];
                status_nxt[3] = 1'b0;
            end
            OP_SHR: begin
                res    = {1'b0, a[WIDTH-1:1]};
                wr_acc = 1'b1;
                upd_zn = 1'b1;
                status_nxt[2] = a[0];
                status_nxt[3] = 1'b0;
            end
            OP_MOV: begin
                res    = acc[data_in[SEL_W-1:0]];
                wr_acc = 1'b1;
                upd_zn = 1'b1;
            end
            OP_CLRF: status_nxt = '0;
            default: ;
        endcase
        if (upd_zn) begin
            status_nxt[0] = (res == '0);
            status_nxt[1] = res[WIDTH-1];
        end
    end

    // One shift-add step per busy cycle; the last step's sum goes straight to the accumulator.
    assign product_nxt = product + (mplier[0] ? mcand : '0);
    assign mul_lo      = product_nxt[WIDTH-1:0];
    assign mul_hi      = product_nxt[2*WIDTH-1:WIDTH];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_ACC; i++) acc[i] <= '0;
            status      <= '0;
            show_status <= 1'b0;
            out_sel     <= '0;
            busy        <= 1'b0;
            mcand       <= '0;
            mplier      <= '0;
            product     <= '0;
            mul_cnt     <= '0;
            mul_sel     <= '0;
        end else if (busy) begin
            product <= product_nxt;
            mcand   <= mcand << 1;
            mplier  <= mplier >> 1;
            mul_cnt <= mul_cnt + 5'd1;
            if (mul_cnt == 5'(WIDTH-1)) begin
                acc[mul_sel] <= mul_lo;
                status       <= {mul_hi != '0, mul_hi != '0, mul_lo[WIDTH-1], mul_lo == '0};
                busy         <= 1'b0;
            end
        end else begin
            out_sel     <= sel;
            show_status <= (op == OP_RDST);
            status      <= status_nxt;
            if (wr_acc) acc[sel] <= res;
            if (op == OP_MUL) begin
                mcand   <= {{WIDTH{1'b0}}, a};
                mplier  <= data_in;
                product <= '0;
                mul_cnt <= '0;
                mul_sel <= sel;
                busy    <= 1'b1;
            end
        end
    end

    assign data_out = show_status ? WIDTH'(status) : acc[out_sel];

endmodule

// File: tb/tb_alu_multi.sv
// tb/tb_alu_multi.sv - randomized and directed self-checking bench for alu_multi
module tb_alu_multi;
    localparam int WIDTH   = 8;
    localparam int NUM_ACC = 2;
    localparam int SEL_W   = 1;
    localparam int MASK    = (1 << WIDTH) - 1;
    localparam int MSB     = 1 << (WIDTH - 1);

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic [3:0]       opcode = 4'h0;
    logic [SEL_W-1:0] sel = '0;
    logic [WIDTH-1:0] data_in = '0;
    logic [WIDTH-1:0] data_out;
    logic             busy;

    int n_checks = 0;
    int n_pass   = 0;

    int macc [NUM_ACC];
    bit mz, mn, mc, mv, mshow, mbusy;
    int mout, mleft, mprod, mtgt;

    always #5 clk = ~clk;

    alu_multi #(.WIDTH(WIDTH), .NUM_ACC(NUM_ACC)) dut (
        .clk(clk), .rst_n(rst_n), .opcode(opcode), .sel(sel),
        .data_in(data_in), .data_out(data_out), .busy(busy)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    function automatic int exp_dout();
        return mshow ? int'({mv, mc, mn, mz}) : macc[mout];
    endfunction

    task automatic model_edge(input int op, input int s, input int d, input bit r);
        int a, res, t;
        if (!r) begin
            foreach (macc[i]) macc[i] = 0;
            {mz, mn, mc, mv, mshow, mbusy} = '0;
            mout = 0;
            return;
        end
        if (mbusy) begin
            mleft--;
            if (mleft == 0) begin
                res = mprod & MASK;
                macc[mtgt] = res;
                mz = (res == 0);
                mn = (res & MSB) != 0;
                mc = (mprod >> WIDTH) != 0;
                mv = mc;
                mbusy = 0;
            end
            return;
        end
        mout  = s;
        mshow = (op == 15);
        a     = macc[s];
        res   = -1;
        case (op)
            1: res = d;
            2, 3: begin
                t   = a + d + ((op == 3 && mc) ? 1 : 0);
                res = t & MASK;
                mc  = t > MASK;
                mv  = ((a ^ res) & (d ^ res) & MSB) != 0;
            end
            4, 5, 12: begin
                t   = a - d - ((op == 5 && mc) ? 1 : 0);
                res = t & MASK;
                mc  = t < 0;
                mv  = ((a ^ d) & (a ^ res) & MSB) != 0;
            end
            6: begin res = a & d; mv = 0; end
            7: begin res = a | d; mv = 0; end
            8: begin res = a ^ d; mv = 0; end
            9: begin mc = (a & MSB) != 0; res = (a << 1) & MASK; mv = 0; end
            10: begin mc = (a & 1) != 0; res = a >> 1; mv = 0; end
            11: begin mprod = a * d; mtgt = s; mleft = WIDTH; mbusy = 1; end
            13: res = macc[d % NUM_ACC];
            14: {mz, mn, mc, mv} = '0;
            default: ;
        endcase
        if (res >= 0) begin
            mz = (res == 0);
            mn = (res & MSB) != 0;
            if (op != 12) macc[s] = res;
        end
    endtask

    task automatic step(input int op, input int s, input int d, input bit r = 1'b1);
        @(negedge clk);
        rst_n   = r;
        opcode  = 4'(op);
        sel     = SEL_W'(s);
        data_in = WIDTH'(d);
        @(posedge clk);
        model_edge(op, s, d, r);
        #1;
        check($sformatf("data_out op=%0d", op), 32'(data_out), exp_dout());
        check($sformatf("busy op=%0d", op), 32'(busy), 32'(mbusy));
    endtask

    task automatic wait_mul(output int cycles);
        cycles = 0;
        for (int i = 0; i < 20 && busy; i++) begin
            cycles++;
            step($urandom_range(0, 15), $urandom_range(0, NUM_ACC - 1), $urandom_range(0, MASK));
        end
    endtask

    initial begin
        int cyc;
        // reset
        step(0, 0, 0, 1'b0);
        step(0, 0, 0, 1'b0);
        step(15, 0, 0);
        check("reset_status", 32'(data_out), 32'h0);
        check("reset_busy", 32'(busy), 32'h0);
        step(0, 1, 0);
        check("reset_acc1", 32'(data_out), 32'h0);

        // add / carry
        step(1, 0, 'hF0);
        step(2, 0, 'h20);
        check("add_res", 32'(data_out), 32'h10);
        step(15, 0, 0);
        check("add_status", 32'(data_out), 32'h4);
        step(3, 0, 'h00);
        check("adc_res", 32'(data_out), 32'h11);

        // overflow / borrow
        step(1, 0, 'h80);
        step(4, 0, 'h01);
        check("sub_res", 32'(data_out), 32'h7F);
        step(15, 0, 0);
        check("sub_status", 32'(data_out), 32'h8);
        step(12, 0, 'h90);
        check("cmp_keeps_acc", 32'(data_out), 32'h7F);
        step(15, 0, 0);
        check("cmp_cn", 32'(data_out & 32'h6), 32'h6);

        // multiple accumulators
        step(1, 0, 'h12);
        step(1, 1, 'h34);
        step(13, 0, 1);
        check("mov_acc0", 32'(data_out), 32'h34);
        step(0, 1, 0);
        check("mov_acc1", 32'(data_out), 32'h34);
        step(8, 0, 'h34);
        check("xor_res", 32'(data_out), 32'h0);
        step(15, 0, 0);
        check("xor_z", 32'(data_out & 32'h1), 32'h1);

        // multiply
        step(1, 0, 'h0F);
        step(11, 0, 'h11);
        wait_mul(cyc);
        check("mul_busy_cycles", 32'(cyc), 32'(WIDTH));
        step(0, 0, 0);
        check("mul_res", 32'(data_out), 32'hFF);
        step(15, 0, 0);
        check("mul_status", 32'(data_out), 32'h2);
        step(1, 0, 'h10);
        step(11, 0, 'h10);
        wait_mul(cyc);
        check("mul2_busy_cycles", 32'(cyc), 32'(WIDTH));
        step(15, 0, 0);
        check("mul2_status", 32'(data_out), 32'hD);

        // reset in the middle of a multiply
        step(1, 0, 'h0F);
        step(11, 0, 'h11);
        repeat (3) step(0, 0, 0);
        step(0, 0, 0, 1'b0);
        check("midreset_busy", 32'(busy), 32'h0);
        check("midreset_acc", 32'(data_out), 32'h0);
        for (int i = 0; i < 2 * WIDTH; i++) step(0, i % NUM_ACC, 0);
        check("no_late_write", 32'(data_out), 32'h0);

        // randomized traffic, including multiplies and occasional resets
        for (int i = 0; i < 600; i++)
            step($urandom_range(0, 15), $urandom_range(0, NUM_ACC - 1), $urandom_range(0, MASK),
                 ($urandom_range(0, 99) != 0));

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

// File: doc/alu_multi.md
Name: alu_multi

Overview:
- Parametrised accumulator ALU, next generation of the byte-serial ALU in the same design.
- Adds configurable data width, multiple selectable accumulators, a full add/sub/logic/shift set with carry and overflow flags, and a multi-cycle shift-add multiplier with a busy indication.
- Driven one opcode per clock from the top-level I/O pins. Result or status is read back on data_out.

Parameters:
- WIDTH, 8, datapath and accumulator width in bits; legal range 4..16.
- NUM_ACC, 2, number of accumulators; power of two, legal range 2..8.
- SEL_W, $clog2(NUM_ACC), accumulator-select width; derived, not overridden.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst_n  input  1  synchronous, active-low reset.
- opcode  input  4  operation code, sampled every cycle.
- sel  input  SEL_W  accumulator index for the current opcode.
- data_in  input  WIDTH  operand.
- data_out  output  WIDTH  acc[out_sel], or the zero-extended status when show_status=1.
- busy  output  1  high while a multiply is in progress.

Behaviour:
- Reset (rst_n=0 at an edge):
  - All acc[i]=0, status=0 (Z,N,C,V), show_status=0, out_sel=0, busy=0.
  - Any in-progress multiply is aborted and its result discarded.
  - data_out=0 the cycle after reset.
- Status bits: [0]=Z, [1]=N, [2]=C, [3]=V. data_out in status mode is {0..., V,C,N,Z}.
- Opcode acceptance:
  - When busy=0, an opcode is accepted each edge.
  - On accept: out_sel<=sel and show_status<=(opcode==F).
  - When busy=1, opcode, sel and data_in are ignored; out_sel and show_status hold.
- Operations, all on A=acc[sel], B=data_in, results written at the accepting edge:
  - 0 NOP: no state change except out_sel and show_status.
  - 1 LD: A<=B. Update Z,N; C,V unchanged.
  - 2 ADD: A<=A+B. Update Z,N; C=carry out; V=signed overflow.
  - 3 ADC: A<=A+B+C. Flags as ADD.
  - 4 SUB: A<=A-B. Update Z,N; C=borrow (1 iff A<B unsigned); V=signed overflow.
  - 5 SBB: A<=A-B-C. Flags as SUB.
  - 6 AND, 7 OR, 8 XOR: bitwise A op B. Update Z,N; C unchanged; V=0.
  - 9 SHL: A<=A<<1. C=old A[WIDTH-1]; Z,N updated; V=0. data_in ignored.
  - A SHR (logical): A<=A>>1. C=old A[0]; Z,N updated; V=0. data_in ignored.
  - B MUL: see below.
  - C CMP: flags as SUB, A unchanged.
  - D MOV: A<=acc[data_in[SEL_W-1:0]]. Update Z,N; C,V unchanged.
  - E CLRF: status<=0.
  - F RDST: no arithmetic; selects status onto data_out from the next cycle.
- Data/status read timing:
  - data_out is combinational from registers: show_status ? status : acc[out_sel].
  - An op accepted at edge t is visible on data_out after edge t.
- MUL, multi-cycle:
  - Accepted at edge t: latch multiplicand=A, multiplier=B, clear a 2*WIDTH product register; busy=1 after edge t.
  - One shift-add step per cycle for WIDTH cycles.
  - At edge t+WIDTH: acc[sel_latched]<=product[WIDTH-1:0]; Z,N from the low half; C=V=(product[2*WIDTH-1:WIDTH]!=0); busy<=0.
  - busy is therefore high for exactly WIDTH cycles. The next opcode is accepted at edge t+WIDTH+1.
  - Arithmetic is unsigned. The target accumulator is fixed at accept time.
- Width rules: all arithmetic is modulo 2^WIDTH. Carry and overflow are taken from WIDTH+1-bit intermediates.
- Reset asserted mid-multiply takes priority over the multiplier step and the final write.

Test Plan:
- Reset: WIDTH=8. Hold rst_n=0 for 2 cycles, then RDST -> data_out=0x00, busy=0; NOP sel=1 -> data_out=0x00.
- Add/carry: LD 0xF0 into acc0; ADD 0x20 -> acc0=0x10; RDST -> status=0x4 (C=1). ADC 0x00 -> acc0=0x11, C=0.
- Overflow/borrow: LD 0x80; SUB 0x01 -> 0x7F, V=1, C=0, status=0x8. CMP 0x90 -> acc unchanged at 0x7F, C=1, N=1.
- Multi-accumulator: LD 0x12 sel=0; LD 0x34 sel=1; MOV sel=0 data_in=1 -> acc0=0x34, acc1=0x34; XOR 0x34 sel=0 -> 0x00, Z=1.
- Multiply: LD 0x0F; MUL 0x11 -> busy high for exactly 8 cycles, then acc=0xFF, C=V=0. Opcodes issued while busy are ignored. LD 0x10; MUL 0x10 -> acc=0x00, Z=1, C=V=1.
- Reset mid-multiply: issue MUL, assert rst_n=0 on the 4th busy cycle -> busy=0 and acc=0 after that edge; no late write occurs afterwards.
